// File: rtl/round_robin_arbiter.sv
// Registered round-robin arbiter: a rotating pointer feeds a programmable
// priority encoder, and grants leave on a valid/ready channel.

// Tree search for the lowest set bit; each node keeps the first valid child.
module priority_search_tree #(
  parameter int WIDTH     = 32,
  parameter int SPLIT     = 2,
  localparam int WIDTH_LOG = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]     vec,
  output logic                 found,
  output logic [WIDTH_LOG-1:0] idx
);

  function automatic int calc_levels(input int w, input int s);
    int lv;
    int rem;
    lv  = 0;
    rem = w;
    for (int i = 0; i < 32; i++) begin
      if (rem > 1) begin
        rem = rem / s;
        lv++;
      end
    end
    return lv;
  endfunction

  localparam int LEVELS = calc_levels(WIDTH, SPLIT);

  logic                 node_vld [WIDTH];
  logic [WIDTH_LOG-1:0] node_idx [WIDTH];
  logic                 pick_vld;
  logic [WIDTH_LOG-1:0] pick_idx;

  // Nodes are reduced in place: node n of a level only reads children at n*SPLIT+k >= n.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      node_vld[i] = vec[i];
      node_idx[i] = WIDTH_LOG'(i);
    end
    for (int l = 0; l < LEVELS; l++) begin
      for (int n = 0; n < WIDTH / SPLIT; n++) begin
        if (n < (WIDTH / (SPLIT ** (l + 1)))) begin
          pick_vld = 1'b0;
          pick_idx = '0;
          for (int k = SPLIT - 1; k >= 0; k--) begin
            if (node_vld[n * SPLIT + k]) begin
              pick_vld = 1'b1;
              pick_idx = node_idx[n * SPLIT + k];
            end
          end
          node_vld[n] = pick_vld;
          node_idx[n] = pick_idx;
        end
      end
    end
    found = node_vld[0];
    idx   = node_idx[0];
  end

endmodule

// Lowest set index at or above enc_pri, wrapping to the lowest set index below it.
module programmable_priority_encoder #(
  parameter int WIDTH     = 32,
  parameter int SPLIT     = 2,
  localparam int WIDTH_LOG = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]     enc_req,
  input  logic [WIDTH_LOG-1:0] enc_pri,
  output logic                 enc_found,
  output logic [WIDTH_LOG-1:0] enc_idx
);

  logic [WIDTH-1:0]     hi_mask;
  logic [WIDTH-1:0]     hi_req;
  logic                 hi_found;
  logic [WIDTH_LOG-1:0] hi_idx;
  logic                 all_found;
  logic [WIDTH_LOG-1:0] all_idx;

  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hi_mask[i] = (WIDTH_LOG'(i) >= enc_pri);
    end
    hi_req = enc_req & hi_mask;
  end

  priority_search_tree #(
    .WIDTH (WIDTH),
    .SPLIT (SPLIT)
  ) u_hi_tree (
    .vec   (hi_req),
    .found (hi_found),
    .idx   (hi_idx)
  );

  priority_search_tree #(
    .WIDTH (WIDTH),
    .SPLIT (SPLIT)
  ) u_all_tree (
    .vec   (enc_req),
    .found (all_found),
    .idx   (all_idx)
  );

  always_comb begin
    enc_found = all_found;
    enc_idx   = hi_found ? hi_idx : all_idx;
  end

endmodule

module round_robin_arbiter #(
  parameter int WIDTH     = 32,
  parameter int SPLIT     = 2,
  localparam int WIDTH_LOG = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     req,
  input  logic                 lck,
  output logic                 grt_vld,
  input  logic                 grt_rdy,
  output logic [WIDTH_LOG-1:0] grt_idx,
  output logic [WIDTH-1:0]     grt_oht,
  output logic [WIDTH_LOG-1:0] ptr
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [WIDTH_LOG-1:0] idx_q, idx_d;
  logic [WIDTH-1:0]     oht_q, oht_d;
  logic [WIDTH_LOG-1:0] ptr_q, ptr_d;

  logic                 hs;
  logic [WIDTH_LOG-1:0] ptr_nxt;
  logic [WIDTH_LOG-1:0] search_pri;
  logic                 enc_found;
  logic [WIDTH_LOG-1:0] enc_idx;

  // A back-to-back search must already see the advanced pointer.
  always_comb begin
    hs         = (state_q == GRANT) & grt_rdy;
    ptr_nxt    = lck ? idx_q : idx_q + WIDTH_LOG'(1);
    search_pri = hs ? ptr_nxt : ptr_q;
  end

  programmable_priority_encoder #(
    .WIDTH (WIDTH),
    .SPLIT (SPLIT)
  ) u_encoder (
    .enc_req   (req),
    .enc_pri   (search_pri),
    .enc_found (enc_found),
    .enc_idx   (enc_idx)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    oht_d   = oht_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (enc_found) begin
          state_d = GRANT;
          idx_d   = enc_idx;
          oht_d   = WIDTH'(1) << enc_idx;
        end
      end
      GRANT: begin
        // Without a handshake the grant is frozen regardless of req.
        if (hs) begin
          ptr_d = ptr_nxt;
          if (enc_found) begin
            idx_d = enc_idx;
            oht_d = WIDTH'(1) << enc_idx;
          end else begin
            state_d = IDLE;
            oht_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        oht_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      oht_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      oht_q   <= oht_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grt_vld = (state_q == GRANT);
  assign grt_idx = idx_q;
  assign grt_oht = oht_q;
  assign ptr     = ptr_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Randomized scoreboard bench for round_robin_arbiter: a search-rule model
// predicts each cycle's outputs and a negedge monitor compares them.
module tb_round_robin_arbiter;

  localparam int W  = 8;
  localparam int WL = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  req = '0;
  logic          lck = 1'b0;
  logic          grt_rdy = 1'b0;
  logic          grt_vld;
  logic [WL-1:0] grt_idx;
  logic [W-1:0]  grt_oht;
  logic [WL-1:0] ptr;

  int n_compared = 0;
  int n_failed   = 0;

  typedef struct packed {
    logic          vld;
    logic [WL-1:0] idx;
    logic [W-1:0]  oht;
    logic [WL-1:0] ptr;
  } exp_t;

  exp_t exp_q[$];

  int   m_vld = 0;
  int   m_idx = 0;
  int   m_ptr = 0;
  int   m_hit;
  exp_t m_exp;

  logic full_load = 1'b0;
  int   next_full = 0;
  int   full_hs   = 0;

  round_robin_arbiter #(
    .WIDTH (W),
    .SPLIT (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .lck     (lck),
    .grt_vld (grt_vld),
    .grt_rdy (grt_rdy),
    .grt_idx (grt_idx),
    .grt_oht (grt_oht),
    .ptr     (ptr)
  );

  always #5 clk = ~clk;

  // Lowest requester at or after p, wrapping; -1 if nobody asks.
  function automatic int search(input logic [W-1:0] r, input int p);
    for (int k = 0; k < W; k++) begin
      if (r[(p + k) % W]) return (p + k) % W;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: evolves the arbiter's observable state and queues the expectation.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_vld = 0;
      m_idx = 0;
      m_ptr = 0;
    end else begin
      if (m_vld == 0) begin
        m_hit = search(req, m_ptr);
        if (m_hit >= 0) begin
          m_vld = 1;
          m_idx = m_hit;
        end
      end else if (grt_rdy) begin
        m_ptr = lck ? m_idx : (m_idx + 1) % W;
        m_hit = search(req, m_ptr);
        if (m_hit >= 0) m_idx = m_hit;
        else m_vld = 0;
      end
      m_exp.vld = (m_vld != 0);
      m_exp.idx = WL'(m_idx);
      m_exp.oht = (m_vld != 0) ? (W'(1) << m_idx) : '0;
      m_exp.ptr = WL'(m_ptr);
      exp_q.push_back(m_exp);
    end
  end

  // Monitor: pops one expectation per presented cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("grt_vld", 32'(grt_vld), 32'(e.vld));
      if (e.vld) checkOutput("grt_idx", 32'(grt_idx), 32'(e.idx));
      checkOutput("grt_oht", 32'(grt_oht), 32'(e.oht));
      checkOutput("ptr", 32'(ptr), 32'(e.ptr));
      if (full_load && grt_vld && grt_rdy) begin
        checkOutput("full_load_seq", 32'(grt_idx), 32'(next_full));
        next_full = (next_full + 1) % W;
        full_hs++;
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] r, input logic rd, input logic l, input int cycles);
    req     = r;
    grt_rdy = rd;
    lck     = l;
    repeat (cycles) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic applyReset();
    rst = 1'b1;
    #1;
    exp_q.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] r;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    checkOutput("reset_vld", 32'(grt_vld), 32'd0);
    checkOutput("reset_ptr", 32'(ptr), 32'd0);
    checkOutput("reset_oht", 32'(grt_oht), 32'd0);

    // Asynchronous reset while granting index 5.
    applyStimulus(8'h20, 1'b0, 1'b0, 2);
    checkOutput("pre_reset_idx", 32'(grt_idx), 32'd5);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_vld", 32'(grt_vld), 32'd0);
    checkOutput("async_rst_idx", 32'(grt_idx), 32'd0);
    checkOutput("async_rst_oht", 32'(grt_oht), 32'd0);
    checkOutput("async_rst_ptr", 32'(ptr), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    applyStimulus(8'h00, 1'b1, 1'b0, 3);
    checkOutput("idle_after_rst", 32'(grt_vld), 32'd0);

    // Rotation between 2 and 7 with wrap.
    applyStimulus(8'h84, 1'b1, 1'b0, 9);
    applyStimulus(8'h00, 1'b1, 1'b0, 2);
    applyReset();

    // Stall: grant held while req changes.
    applyStimulus(8'h18, 1'b0, 1'b0, 1);
    applyStimulus(8'h01, 1'b0, 1'b0, 4);
    checkOutput("stall_idx", 32'(grt_idx), 32'd3);
    checkOutput("stall_ptr", 32'(ptr), 32'd0);
    applyStimulus(8'h01, 1'b1, 1'b0, 1);
    checkOutput("stall_release_ptr", 32'(ptr), 32'd4);
    checkOutput("stall_release_idx", 32'(grt_idx), 32'd0);
    applyStimulus(8'h00, 1'b1, 1'b0, 2);
    applyReset();

    // Lock: three locked handshakes, then release.
    applyStimulus(8'h06, 1'b1, 1'b1, 4);
    checkOutput("lock_idx", 32'(grt_idx), 32'd1);
    checkOutput("lock_ptr", 32'(ptr), 32'd1);
    applyStimulus(8'h06, 1'b1, 1'b0, 1);
    checkOutput("unlock_idx", 32'(grt_idx), 32'd2);
    checkOutput("unlock_ptr", 32'(ptr), 32'd2);
    applyStimulus(8'h00, 1'b1, 1'b0, 2);
    applyReset();

    // Drain: single pulse on requester 6.
    applyStimulus(8'h40, 1'b0, 1'b0, 1);
    checkOutput("drain_idx", 32'(grt_idx), 32'd6);
    applyStimulus(8'h00, 1'b1, 1'b0, 1);
    checkOutput("drain_ptr", 32'(ptr), 32'd7);
    checkOutput("drain_vld", 32'(grt_vld), 32'd0);
    applyStimulus(8'h00, 1'b1, 1'b0, 2);
    applyReset();

    // Full load with random back-pressure.
    full_load = 1'b1;
    next_full = 0;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(8'hFF, 1'($urandom_range(0, 1)), 1'b0, 1);
    end
    full_load = 1'b0;
    if (full_hs < 20) checkOutput("full_load_handshakes", 32'(full_hs), 32'd20);
    applyStimulus(8'h00, 1'b1, 1'b0, 2);

    // Random traffic with occasional locks and resets.
    for (int i = 0; i < 1500; i++) begin
      r = W'($urandom & $urandom);
      applyStimulus(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), 1);
      if ($urandom_range(0, 99) == 0) applyReset();
    end
    applyStimulus(8'h00, 1'b1, 1'b0, 4);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
